// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - framed packet assembler behind the UART byte receiver
//
// Consumes the receiver's rx_done/data_byte strobe, assembles frames of the form
// 0xAA, LEN, LEN payload bytes, CHK (CHK = LEN + payload, mod 256) into a 16-entry
// payload buffer, and presents checked packets over a pkt_valid/pkt_ready handshake.
// Also owns the receiver's baud code and only changes it between frames.
//
// Ports:
//   mclk, rst_n          clock, asynchronous active-low reset
//   rx_done, data_byte   per-byte strobe and data from the receiver
//   uart_state           receiver busy; freezes the inter-byte timeout
//   cfg_baud_we/cfg_baud baud change request (deferred until idle)
//   baud_set             baud code driven to the receiver
//   pkt_valid/pkt_ready  packet handshake; pkt_len is the held payload length
//   pkt_rd_addr/_data    combinational payload read port
//   busy                 frame in progress or packet held
//   err_chk/_timeout/_overflow  one-cycle error pulses
module uart_rx_pkt_ctrl #(
  parameter int          TIMEOUT_CYC  = 50000,
  parameter int          MAX_LEN      = 16,
  parameter logic [3:0]  BAUD_DEFAULT = 4'd0
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] data_byte,
  input  logic       uart_state,
  input  logic       cfg_baud_we,
  input  logic [3:0] cfg_baud,
  output logic [3:0] baud_set,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [4:0] pkt_len,
  input  logic [3:0] pkt_rd_addr,
  output logic [7:0] pkt_rd_data,
  output logic       busy,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_overflow
);

  localparam int            CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_DATA, S_CHK, S_HOLD} state_e;

  state_e        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_chk_q, err_chk_d;
  logic          err_to_q, err_to_d;
  logic          err_ov_q, err_ov_d;
  logic          timeout_hit;
  logic          buf_we;
  logic [7:0]    buf_q [16];
  logic [3:0]    baud_q, baud_d, pend_val_q, pend_val_d;
  logic          pend_q, pend_d;
  logic          apply;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    cnt_d       = '0;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    err_ov_d    = 1'b0;
    timeout_hit = 1'b0;
    buf_we      = 1'b0;

    // Inter-byte timeout only runs while a frame is being collected.
    if (state_q == S_LEN || state_q == S_DATA || state_q == S_CHK) begin
      if (rx_done) begin
        cnt_d = '0;
      end else if (uart_state) begin
        cnt_d = cnt_q;
      end else if (cnt_inc == TO_LIM) begin
        timeout_hit = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    case (state_q)
      S_HUNT: begin
        if (rx_done && data_byte == 8'hAA) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_done) begin
          if (data_byte == 8'd0 || data_byte > 8'(MAX_LEN)) begin
            err_ov_d = 1'b1;
            state_d  = S_HUNT;
          end else begin
            len_d   = data_byte[4:0];
            sum_d   = data_byte;
            idx_d   = 4'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_done) begin
          buf_we = 1'b1;
          sum_d  = sum_q + data_byte;
          idx_d  = idx_q + 4'd1;
          if ({1'b0, idx_q} + 5'd1 == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (data_byte == sum_q) begin
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        // Bytes arriving while a packet is held are dropped, even on the handshake cycle.
        if (rx_done)   err_ov_d = 1'b1;
        if (pkt_ready) state_d  = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase

    // timeout_hit implies no rx_done, so it never collides with another error.
    if (timeout_hit) begin
      err_to_d = 1'b1;
      state_d  = S_HUNT;
    end
  end

  // Baud changes wait for an idle receiver between frames; a write that lands
  // on an apply cycle bypasses the pending register.
  assign apply = (state_q == S_HUNT) && !uart_state;

  always_comb begin
    baud_d     = baud_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (cfg_baud_we) begin
      if (apply) begin
        baud_d = cfg_baud;
        pend_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_val_d = cfg_baud;
      end
    end else if (apply && pend_q) begin
      baud_d = pend_val_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      len_q      <= 5'd0;
      sum_q      <= 8'd0;
      idx_q      <= 4'd0;
      cnt_q      <= '0;
      err_chk_q  <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      baud_q     <= BAUD_DEFAULT;
      pend_q     <= 1'b0;
      pend_val_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_chk_q  <= err_chk_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
      baud_q     <= baud_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (buf_we) buf_q[idx_q] <= data_byte;
  end

  assign pkt_rd_data  = buf_q[pkt_rd_addr];
  assign pkt_valid    = (state_q == S_HOLD);
  assign busy         = (state_q != S_HUNT);
  assign pkt_len      = len_q;
  assign baud_set     = baud_q;
  assign err_chk      = err_chk_q;
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - self-checking bench for uart_rx_pkt_ctrl
module tb_uart_rx_pkt_ctrl;

  localparam int         TO       = 40;
  localparam logic [3:0] BAUD_DEF = 4'd2;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] data_byte = 8'h00;
  logic       uart_state = 1'b0;
  logic       cfg_baud_we = 1'b0;
  logic [3:0] cfg_baud = 4'h0;
  logic [3:0] baud_set;
  logic       pkt_valid;
  logic       pkt_ready = 1'b0;
  logic [4:0] pkt_len;
  logic [3:0] pkt_rd_addr = 4'h0;
  logic [7:0] pkt_rd_data;
  logic       busy, err_chk, err_timeout, err_overflow;

  int total = 0;
  int bad = 0;

  uart_rx_pkt_ctrl #(.TIMEOUT_CYC(TO), .MAX_LEN(16), .BAUD_DEFAULT(BAUD_DEF)) dut (
    .mclk(mclk), .rst_n(rst_n), .rx_done(rx_done), .data_byte(data_byte),
    .uart_state(uart_state), .cfg_baud_we(cfg_baud_we), .cfg_baud(cfg_baud),
    .baud_set(baud_set), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_len(pkt_len), .pkt_rd_addr(pkt_rd_addr), .pkt_rd_data(pkt_rd_data),
    .busy(busy), .err_chk(err_chk), .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 mclk = ~mclk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: collects the bytes of the current frame in a
  // queue and judges the frame once it is complete.
  logic [7:0] fq[$];
  logic [7:0] m_pay [16];
  bit         m_hold = 0;
  int         m_len = 0;
  int         m_idle = 0;
  logic [3:0] m_baud = BAUD_DEF;
  bit         m_pend = 0;
  logic [3:0] m_pval = 4'h0;
  bit         e_chk = 0, e_to = 0, e_ov = 0;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      m_hold = 0; m_len = 0; m_idle = 0;
      m_baud = BAUD_DEF; m_pend = 0;
      e_chk = 0; e_to = 0; e_ov = 0;
    end else begin
      bit idle_now;
      int s;
      idle_now = (fq.size() == 0) && !m_hold;
      if (cfg_baud_we) begin
        if (idle_now && !uart_state) begin m_baud = cfg_baud; m_pend = 0; end
        else begin m_pend = 1; m_pval = cfg_baud; end
      end else if (idle_now && !uart_state && m_pend) begin
        m_baud = m_pval; m_pend = 0;
      end
      e_chk = 0; e_to = 0; e_ov = 0;
      if (m_hold) begin
        if (rx_done) e_ov = 1;
        if (pkt_ready) m_hold = 0;
      end else if (fq.size() == 0) begin
        if (rx_done && data_byte == 8'hAA) begin fq.push_back(data_byte); m_idle = 0; end
      end else if (rx_done) begin
        m_idle = 0;
        fq.push_back(data_byte);
        if (fq.size() == 2) begin
          if (data_byte == 0 || data_byte > 16) begin e_ov = 1; fq.delete(); end
          else m_len = int'(data_byte);
        end else if (fq.size() == m_len + 3) begin
          s = 0;
          for (int i = 1; i <= m_len + 1; i++) s += int'(fq[i]);
          if ((s % 256) == int'(data_byte)) begin
            m_hold = 1;
            for (int i = 0; i < m_len; i++) m_pay[i] = fq[i+2];
          end else e_chk = 1;
          fq.delete();
        end
      end else if (!uart_state) begin
        m_idle++;
        if (m_idle == TO) begin e_to = 1; fq.delete(); m_idle = 0; end
      end
    end
  end

  always @(negedge mclk) begin
    cmp("pkt_valid", 32'(pkt_valid), 32'(m_hold));
    cmp("busy", 32'(busy), 32'((fq.size() != 0) || m_hold));
    cmp("pkt_len", 32'(pkt_len), 32'(m_len));
    cmp("baud_set", 32'(baud_set), 32'(m_baud));
    cmp("err_chk", 32'(err_chk), 32'(e_chk));
    cmp("err_timeout", 32'(err_timeout), 32'(e_to));
    cmp("err_overflow", 32'(err_overflow), 32'(e_ov));
    if (m_hold) cmp("pkt_rd_data", 32'(pkt_rd_data), 32'(m_pay[pkt_rd_addr]));
  end

  task automatic send(input logic [7:0] b);
    @(posedge mclk); #2 rx_done = 1'b1; data_byte = b;
    @(posedge mclk); #2 rx_done = 1'b0;
  endtask

  task automatic handshake();
    @(posedge mclk); #2 pkt_ready = 1'b1;
    @(posedge mclk); #2 pkt_ready = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] v);
    @(posedge mclk); #2 cfg_baud_we = 1'b1; cfg_baud = v;
    @(posedge mclk); #2 cfg_baud_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp);
    @(posedge mclk); #2 pkt_rd_addr = a;
    #1 cmp("lit_rd_data", 32'(pkt_rd_data), 32'(exp));
  endtask

  initial begin
    repeat (3) @(posedge mclk);
    #2 rst_n = 1'b1;
    cmp("lit_reset_baud", 32'(baud_set), 32'(BAUD_DEF));
    cmp("lit_reset_busy", 32'(busy), 0);
    cmp("lit_reset_valid", 32'(pkt_valid), 0);
    cmp("lit_reset_len", 32'(pkt_len), 0);

    // basic packet, long hold, handshake
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    cmp("lit_t1_valid", 32'(pkt_valid), 1);
    cmp("lit_t1_len", 32'(pkt_len), 3);
    rd_chk(4'd0, 8'h11); rd_chk(4'd1, 8'h22); rd_chk(4'd2, 8'h33);
    repeat (100) @(posedge mclk);
    #2 cmp("lit_t1_hold", 32'(pkt_valid), 1);
    handshake();
    cmp("lit_t1_drop", 32'(pkt_valid), 0);
    cmp("lit_t1_busy", 32'(busy), 0);

    // bad checksum, then a good single-byte frame
    send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h04);
    cmp("lit_t2_errchk", 32'(err_chk), 1);
    cmp("lit_t2_novalid", 32'(pkt_valid), 0);
    send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
    cmp("lit_t2_valid", 32'(pkt_valid), 1);
    cmp("lit_t2_len", 32'(pkt_len), 1);
    rd_chk(4'd0, 8'h7F);
    handshake();

    // junk byte and illegal lengths
    send(8'h55);
    cmp("lit_t3_junk", 32'(busy), 0);
    send(8'hAA); send(8'h00);
    cmp("lit_t3_len0", 32'(err_overflow), 1);
    send(8'hAA); send(8'h11);
    cmp("lit_t3_len17", 32'(err_overflow), 1);
    cmp("lit_t3_hunt", 32'(busy), 0);

    // maximum length frame, overflow while held, then a fresh frame
    send(8'hAA); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h88);
    cmp("lit_t4_valid", 32'(pkt_valid), 1);
    cmp("lit_t4_len", 32'(pkt_len), 16);
    rd_chk(4'd15, 8'h0F);
    send(8'hAA);
    cmp("lit_t4_ovf", 32'(err_overflow), 1);
    cmp("lit_t4_keep", 32'(pkt_valid), 1);
    rd_chk(4'd15, 8'h0F);
    handshake();
    send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
    cmp("lit_t4_new", 32'(pkt_valid), 1);
    handshake();

    // timeout at exactly TO idle cycles after the last byte
    send(8'hAA); send(8'h04); send(8'h01);
    repeat (TO - 1) @(posedge mclk);
    #2 cmp("lit_t5_early", 32'(err_timeout), 0);
    @(posedge mclk);
    #2 cmp("lit_t5_to", 32'(err_timeout), 1);
    cmp("lit_t5_hunt", 32'(busy), 0);
    uart_state = 1'b1;
    send(8'hAA); send(8'h04); send(8'h01);
    repeat (3 * TO) @(posedge mclk);
    #2 cmp("lit_t5_frozen", 32'(busy), 1);
    uart_state = 1'b0;
    repeat (TO + 2) @(posedge mclk);
    #2 cmp("lit_t5_release", 32'(busy), 0);

    // deferred baud change
    send(8'hAA); send(8'h03);
    cfg(4'h4);
    cmp("lit_t6_defer", 32'(baud_set), 32'(BAUD_DEF));
    send(8'h01); send(8'h02); send(8'h03); send(8'h09);
    cmp("lit_t6_held", 32'(baud_set), 32'(BAUD_DEF));
    handshake();
    repeat (2) @(posedge mclk);
    #2 cmp("lit_t6_apply", 32'(baud_set), 4);
    cfg(4'h7);
    cmp("lit_t6_direct", 32'(baud_set), 7);
    uart_state = 1'b1;
    cfg(4'h5);
    cmp("lit_t6_busyrx", 32'(baud_set), 7);
    uart_state = 1'b0;
    repeat (2) @(posedge mclk);
    #2 cmp("lit_t6_late", 32'(baud_set), 5);

    // reset mid-frame
    send(8'hAA); send(8'h02); send(8'h11);
    rst_n = 1'b0;
    #1 cmp("lit_rst_baud", 32'(baud_set), 32'(BAUD_DEF));
    cmp("lit_rst_busy", 32'(busy), 0);
    cmp("lit_rst_len", 32'(pkt_len), 0);
    @(posedge mclk); #2 rst_n = 1'b1;
    send(8'hAA); send(8'h01); send(8'h33); send(8'h34);
    cmp("lit_rst_after", 32'(pkt_valid), 1);
    handshake();
    repeat (3) @(posedge mclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Packet-level controller that sits directly behind the UART byte receiver. It consumes the receiver's per-byte `rx_done`/`data_byte` strobe and assembles framed command packets into a 16-byte payload buffer. Each packet is checked for length and checksum, then handed to the downstream consumer over a valid/ready handshake. The block also owns the receiver's `baud_set` configuration and applies baud changes only between frames.

## Interface
- `TIMEOUT_CYC`, default 50000: inter-byte timeout in `mclk` cycles (1 ms at 50 MHz).
- `MAX_LEN`, default 16: maximum payload length; also the buffer depth (1..16).
- `BAUD_DEFAULT`, default 0: `baud_set` value after reset.

- `mclk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_done` in 1: one-cycle strobe from the byte receiver; `data_byte` is valid in that cycle.
- `data_byte` in 8: received byte.
- `uart_state` in 1: receiver busy; the timeout counter holds while high.
- `cfg_baud_we` in 1: one-cycle write strobe for `cfg_baud`.
- `cfg_baud` in 4: requested baud code.
- `baud_set` out 4: baud code driven to the receiver.
- `pkt_valid` out 1: a complete, checked packet is in the buffer.
- `pkt_ready` in 1: consumer accepts the packet.
- `pkt_len` out 5: payload length of the held packet.
- `pkt_rd_addr` in 4: payload read index.
- `pkt_rd_data` out 8: `buffer[pkt_rd_addr]`, combinational read.
- `busy` out 1: high in any state other than HUNT.
- `err_chk`, `err_timeout`, `err_overflow` out 1 each: one-cycle error pulses.

## Operation
- Frame format: `0xAA`, LEN, LEN payload bytes, CHK.
- CHK is the 8-bit sum (mod 256) of LEN and all payload bytes.
- All actions below are taken only in cycles where `rx_done` is 1.

State machine (HUNT, LEN, DATA, CHK, HOLD):
- HUNT:
  - byte `0xAA` -> LEN; any other byte is ignored silently.
- LEN:
  - LEN of 0 or LEN > `MAX_LEN` -> pulse `err_overflow`, go to HUNT.
  - Otherwise store `pkt_len` <= LEN, sum <= LEN, idx <= 0, go to DATA.
- DATA:
  - Write `buffer[idx]` <= byte, sum += byte, idx++.
  - The byte with idx == LEN-1 moves the FSM to CHK.
- CHK:
  - byte == sum -> HOLD, with `pkt_valid` set.
  - Mismatch -> pulse `err_chk`, go to HUNT. Buffer contents are don't-care.
- HOLD:
  - `pkt_valid` = 1. `pkt_len` and the buffer are frozen.
  - The cycle with `pkt_valid & pkt_ready` ends the transfer; the FSM goes to HUNT.
  - Any `rx_done` while in HOLD, including the handshake cycle, drops the byte and pulses `err_overflow`.

Timeout:
- A counter runs in LEN, DATA and CHK.
- It clears on `rx_done` and holds while `uart_state` = 1.
- On reaching `TIMEOUT_CYC` -> pulse `err_timeout`, go to HUNT, clear the counter.
- The counter is cleared in HUNT and HOLD.

Baud configuration:
- `cfg_baud_we` latches `cfg_baud` into a pending register and sets a pending flag. A later write overwrites the pending value.
- The pending value is applied to `baud_set` on the first cycle with state == HUNT and `uart_state` == 0. The flag clears in that same cycle.
- If the write strobe and the apply condition occur in the same cycle, the new value is applied directly.

Reset:
- Asynchronous. State = HUNT.
- `baud_set` = `BAUD_DEFAULT`.
- `pkt_valid`, `busy` and all `err_*` = 0.
- `pkt_len` = 0 and the pending flag = 0.
- Buffer contents are not reset.
- Reset asserted mid-frame or during HOLD discards the packet.

## Timing
- All outputs except `pkt_rd_data` are registered.
- `pkt_valid` rises one cycle after the CHK byte's `rx_done` cycle.
- `pkt_valid` falls the cycle after the handshake.
- Error pulses are one cycle wide, asserted the cycle after the triggering `rx_done` or timeout count.
- `busy` tracks the registered state.
- `pkt_rd_data` reflects `pkt_rd_addr` in the same cycle.
- `baud_set` changes one cycle after the apply condition.
- At most one error pulse is asserted per cycle.
- Timeout arithmetic: counter width is clog2(`TIMEOUT_CYC`+1); the counter saturates only through the HUNT transition.

## Test plan
- Send `AA 03 11 22 33 69` -> `pkt_valid`=1, `pkt_len`=3, buffer[0..2] = 11/22/33. Hold `pkt_ready`=0 for 100 cycles: `pkt_valid` stays 1. Pulse `pkt_ready` -> `pkt_valid`=0 next cycle, `busy`=0.
- Send `AA 02 01 02 04` (correct CHK is 05) -> one `err_chk` pulse, no `pkt_valid`. Then a good frame `AA 01 7F 80` -> `pkt_valid`, `pkt_len`=1.
- Send `55 AA 00` and then `AA 11` -> no reaction to `55`; `err_overflow` pulses after `00` and after `11`; FSM back in HUNT.
- Send `AA 04 01`, then no `rx_done` for `TIMEOUT_CYC` cycles with `uart_state`=0 -> `err_timeout` pulses exactly at the count. Repeat with `uart_state`=1 held high -> no timeout.
- While in HOLD, send byte `AA` -> `err_overflow`; the held packet is unchanged. After the handshake, a new frame is accepted normally.
- `cfg_baud_we` with `cfg_baud`=4 during DATA -> `baud_set` unchanged until the frame ends in HUNT with `uart_state`=0, then 4. Assert reset mid-frame -> `baud_set`=`BAUD_DEFAULT`, `busy`=0.
